// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the sequential fetch PC, issues one outstanding
// imem read at a time and buffers {pc, instr} pairs in a first-word-fall-through FIFO.
//
//   state | meaning
//   IDLE  | no read outstanding; issue next fetch when a slot is free
//   WAIT  | read outstanding, response will be enqueued
//   DROP  | read outstanding but redirected; response will be discarded
module instr_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         imem_req,
   output logic [31:0]                  imem_addr,
   input  logic                         imem_ack,
   input  logic [31:0]                  imem_rdata,
   input  logic                         flush,
   input  logic [31:0]                  flush_pc,
   input  logic                         deq,
   output logic                         valid,
   output logic [31:0]                  instr_out,
   output logic [31:0]                  pc_out,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [31:0]   NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          issue;
   logic          enq;
   logic          deq_take;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      enq       = 1'b0;
      case (state)
         IDLE: begin
            // A free slot is judged before any same-cycle dequeue.
            if (!flush && (count < FULL_COUNT)) begin
               state_nxt = WAIT;
               issue     = 1'b1;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               state_nxt = IDLE;
               enq       = !flush;
            end else if (flush) begin
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (imem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign deq_take  = deq && valid && !flush;
   assign imem_req  = (state != IDLE);
   assign imem_addr = req_pc;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         state <= state_nxt;
         if (issue) req_pc <= fetch_pc;

         if (flush)    fetch_pc <= flush_pc & ~32'h3;
         else if (enq) fetch_pc <= fetch_pc + 32'd4;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (enq)      wr_ptr <= wr_ptr + 1'b1;
            if (deq_take) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq_take})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset; occupancy is tracked by count and the pointers.
   always_ff @(posedge clock) begin
      if (reset && enq) begin
         pc_mem[wr_ptr]    <= req_pc;
         instr_mem[wr_ptr] <= imem_rdata;
      end
   end

   assign valid     = (count != '0);
   assign instr_out = valid ? instr_mem[rd_ptr] : NOP_INSTR;
   assign pc_out    = valid ? pc_mem[rd_ptr]    : 32'h0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus random traffic, all
// compared each cycle against a transaction-level queue model.
module tb_instr_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        flush;
   logic [31:0] flush_pc;
   logic        deq;
   logic        valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [2:0]  count;

   instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .flush(flush), .flush_pc(flush_pc), .deq(deq),
      .valid(valid), .instr_out(instr_out), .pc_out(pc_out), .count(count)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: a queue of {pc, instr} plus the single outstanding read.
   logic [63:0] q[$];
   logic        m_busy;
   logic        m_stale;
   logic [31:0] m_addr;
   logic [31:0] m_fetch;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      logic take;
      if (!reset) begin
         q.delete();
         m_busy  = 1'b0;
         m_stale = 1'b0;
         m_fetch = RESET_PC;
         m_addr  = RESET_PC;
      end else begin
         take = deq && (q.size() > 0) && !flush;
         if (take) void'(q.pop_front());
         if (m_busy) begin
            if (imem_ack) begin
               m_busy = 1'b0;
               if (!m_stale && !flush) begin
                  q.push_back({m_addr, imem_rdata});
                  m_fetch = m_fetch + 32'd4;
               end
            end else if (flush) begin
               m_stale = 1'b1;
            end
         end else if (!flush && (q.size() + (take ? 1 : 0)) < DEPTH) begin
            m_busy  = 1'b1;
            m_stale = 1'b0;
            m_addr  = m_fetch;
         end
         if (flush) begin
            q.delete();
            m_fetch = flush_pc & ~32'h3;
         end
      end
   endtask

   task automatic check_all();
      check_val("imem_req", imem_req, m_busy);
      if (m_busy) check_val("imem_addr", imem_addr, m_addr);
      check_val("count", count, q.size());
      check_val("valid", valid, q.size() != 0);
      check_val("instr_out", instr_out, (q.size() != 0) ? q[0][31:0]  : 32'h0000_0013);
      check_val("pc_out",    pc_out,    (q.size() != 0) ? q[0][63:32] : 32'h0);
   endtask

   // Drive one cycle of inputs, clock it, update the model, then compare.
   task automatic step(input logic r, input logic a, input logic [31:0] rd,
                       input logic f, input logic [31:0] fp, input logic d);
      reset = r; imem_ack = a; imem_rdata = rd; flush = f; flush_pc = fp; deq = d;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_all();
   endtask

   task automatic idle_step();
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!imem_req && n < 10) begin
         idle_step();
         n++;
      end
      check_val("wait_req_timeout", imem_req, 1'b1);
   endtask

   initial begin
      logic a, f, d, r;
      logic [31:0] fp;
      reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; flush = 1'b0; flush_pc = '0; deq = 1'b0;
      q.delete(); m_busy = 0; m_stale = 0; m_fetch = RESET_PC; m_addr = RESET_PC;
      @(negedge clock);

      // 1: reset, first fetch at RESET_PC, then next fetch at +4
      do_reset(3);
      idle_step();
      check_val("t1_req", imem_req, 1'b1);
      check_val("t1_addr", imem_addr, 32'h0);
      step(1'b1, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
      check_val("t1_instr", instr_out, 32'h0050_0093);
      check_val("t1_pc", pc_out, 32'h0);
      check_val("t1_valid", valid, 1'b1);
      idle_step();
      check_val("t1_next_addr", imem_addr, 32'h4);

      // 2: fill to DEPTH, requests stop, one deq reopens fetch at 16
      for (int i = 0; i < 12; i++) step(1'b1, imem_req, 32'h1000 + i, 1'b0, 32'h0, 1'b0);
      check_val("t2_full", count, 3'd4);
      check_val("t2_noreq", imem_req, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check_val("t2_after_deq", count, 3'd3);
      idle_step();
      check_val("t2_req16", imem_req, 1'b1);
      check_val("t2_addr16", imem_addr, 32'h10);

      // 3: flush while waiting on addr 8, late ack is dropped
      do_reset(1);
      for (int i = 0; i < 5; i++) step(1'b1, imem_req, 32'h2000 + i, 1'b0, 32'h0, 1'b0);
      check_val("t3_wait8", imem_addr, 32'h8);
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      idle_step();
      step(1'b1, 1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0);
      check_val("t3_count", count, 3'd0);
      wait_req();
      check_val("t3_addr", imem_addr, 32'h100);
      step(1'b1, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b0);
      check_val("t3_pc", pc_out, 32'h100);

      // 4: flush and ack together, target low bits masked
      wait_req();
      step(1'b1, 1'b1, 32'hBAD0, 1'b1, 32'h203, 1'b0);
      check_val("t4_count", count, 3'd0);
      wait_req();
      check_val("t4_addr", imem_addr, 32'h200);

      // 5: deq while empty; deq with enqueue at count 2
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check_val("t5_empty_count", count, 3'd0);
      check_val("t5_nop", instr_out, 32'h0000_0013);
      while (count < 3'd2) begin
         if (imem_req) step(1'b1, 1'b1, $urandom, 1'b0, 32'h0, 1'b0);
         else idle_step();
      end
      wait_req();
      step(1'b1, 1'b1, 32'h5555, 1'b0, 32'h0, 1'b1);
      check_val("t5_deq_enq", count, 3'd2);

      // 6: reset during WAIT with a coincident ack
      wait_req();
      step(1'b0, 1'b1, 32'h6666, 1'b0, 32'h0, 1'b0);
      check_val("t6_count", count, 3'd0);
      check_val("t6_req", imem_req, 1'b0);
      idle_step();
      check_val("t6_addr", imem_addr, RESET_PC);

      // random traffic, including redirects near the top of the address space
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 199) != 0);
         a  = imem_req && ($urandom_range(0, 1) == 1);
         f  = ($urandom_range(0, 14) == 0);
         d  = ($urandom_range(0, 2) != 0);
         fp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         step(r, a, $urandom, f, fp, d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
